vga_pixel_out: RTL and testbench

//  Downstream stage of the tile display address generator. Pops 24-bit packed words from the display FIFO
//  (FWFT) and unpacks each word into 8 pixels of 3-bit RGB. Generates 640x480 VGA sync from one system clock

---
 rtl/vga_pixel_out.sv | 117 +++++++++++
 tb/tb_vga_pixel_out.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_out.sv
// VGA pixel output stage: unpacks 8-pixel FIFO words into 3-bit RGB and
// generates 640x480 sync timing from a divided pixel-rate enable.
module vga_pixel_out #(
  parameter int unsigned PIX_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [24:0] fifo_dout,
  output logic        fifo_ren,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  rgb,
  output logic        active,
  output logic        underflow
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [20:0]   shreg;

  logic pix_tick_c;
  logic visible_c;
  logic load_c;
  logic hs_win_c;
  logic vs_win_c;
  logic unused_dout_msb;

  assign unused_dout_msb = fifo_dout[24];

  // Timing decode from the current counter position
  always_comb begin
    pix_tick_c = (state == RUN) && (div_cnt == DW'(PIX_DIV - 1));
    visible_c  = (h_cnt < HW'(H_VIS)) && (v_cnt < VW'(V_VIS));
    load_c     = pix_tick_c && visible_c && (h_cnt[2:0] == 3'd0);
    hs_win_c   = (h_cnt >= HW'(HS_START)) && (h_cnt <= HW'(HS_END));
    vs_win_c   = (v_cnt >= VW'(VS_START)) && (v_cnt <= VW'(VS_END));
  end

  // Pop must coincide with the capture edge since the FIFO is first-word-fall-through
  assign fifo_ren = load_c && !fifo_empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      shreg     <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      rgb       <= 3'd0;
      active    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= RUN;
        end
        RUN: begin
          div_cnt <= pix_tick_c ? '0 : div_cnt + DW'(1);
          if (pix_tick_c) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
              h_cnt <= '0;
              v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
              h_cnt <= h_cnt + HW'(1);
            end
            hsync  <= !hs_win_c;
            vsync  <= !vs_win_c;
            active <= visible_c;
            if (load_c) begin
              // An empty slot is blanked for all 8 pixels rather than deferred
              if (!fifo_empty) begin
                rgb   <= fifo_dout[2:0];
                shreg <= fifo_dout[23:3];
              end else begin
                rgb       <= 3'd0;
                shreg     <= '0;
                underflow <= 1'b1;
              end
            end else if (visible_c) begin
              rgb   <= shreg[2:0];
              shreg <= {3'd0, shreg[20:3]};
            end else begin
              rgb <= 3'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Randomized bench for vga_pixel_out on a reduced raster, checked every clock
// against a pixel-index reference model and a queue-based FIFO.
module tb_vga_pixel_out;

  localparam int PD     = 2;
  localparam int H_VIS  = 64;
  localparam int H_FP   = 8;
  localparam int H_SYNC = 12;
  localparam int H_BP   = 4;
  localparam int V_VIS  = 8;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FR     = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [24:0] fifo_dout = '0;
  logic        fifo_ren;
  logic        hsync, vsync, active, underflow;
  logic [2:0]  rgb;

  vga_pixel_out #(
    .PIX_DIV(PD), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_ren(fifo_ren), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .active(active), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // FIFO contents and stimulus controls
  logic [24:0] fq[$];
  bit  feed_en = 0;
  bit  starve_en = 0;
  int  starve_pix = 0;
  bit  chk_en = 0;

  // Reference model: pixel index since RUN entry drives everything
  bit          running = 0;
  int          run_cyc = 0;
  logic [23:0] cur_word = '0;
  bit          e_hs = 1, e_vs = 1, e_act = 0, e_uf = 0;
  logic [2:0]  e_rgb = '0;
  int          frame_pops = 0;
  bit          frame_clean = 0;
  int          cyc = 0;
  int          last_fall = -1;
  bit          prev_hs = 1;

  function automatic bit is_tick(input int rc);
    return (rc % PD) == PD - 1;
  endfunction

  function automatic bit is_vis(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  function automatic bit exp_pop();
    int p;
    p = run_cyc / PD;
    return running && !rst && is_tick(run_cyc) && is_vis(p) && ((p % HT) % 8 == 0) && !fifo_empty;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      running = 0; e_hs = 1; e_vs = 1; e_act = 0; e_uf = 0; e_rgb = 0;
      cur_word = 0; frame_clean = 0; frame_pops = 0;
    end else if (!running) begin
      if (!fifo_empty) begin
        running = 1; run_cyc = 0; frame_pops = 0; frame_clean = 1;
      end
    end else begin
      if (fifo_ren) frame_pops++;
      if (is_tick(run_cyc)) begin
        int p, h, v, k;
        p = run_cyc / PD;
        h = p % HT;
        v = (p / HT) % VT;
        k = h % 8;
        e_hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        e_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        e_act = is_vis(p);
        if (is_vis(p)) begin
          if (k == 0) begin
            if (!fifo_empty) cur_word = fq[0][23:0];
            else begin
              cur_word = '0; e_uf = 1; frame_clean = 0;
            end
          end
          e_rgb = cur_word[3*k +: 3];
        end else begin
          e_rgb = 0;
        end
        if ((p % FR) == FR - 1) begin
          if (frame_clean) check("frame_pops", frame_pops, (H_VIS / 8) * V_VIS);
          frame_pops = 0;
          frame_clean = !e_uf;
        end
      end
      run_cyc++;
    end
    if (fifo_ren && fq.size() > 0) void'(fq.pop_front());
  end

  // Drive FIFO view, then check the DUT against the model
  always @(negedge clk) begin
    #1;
    if (feed_en)
      while (fq.size() < 4) fq.push_back({1'($urandom), 24'($urandom)});
    fifo_empty = (fq.size() == 0) ||
                 (starve_en && running && is_tick(run_cyc) && ((run_cyc / PD) % FR == starve_pix));
    fifo_dout  = (fq.size() > 0) ? fq[0] : 25'($urandom);
    #1;
    if (chk_en) begin
      check("fifo_ren", fifo_ren, exp_pop());
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("rgb", rgb, e_rgb);
      check("active", active, e_act);
      check("underflow", underflow, e_uf);
      if (rst) last_fall = -1;
      else if (prev_hs && !hsync) begin
        if (last_fall >= 0) check("line_period", cyc - last_fall, HT * PD);
        last_fall = cyc;
      end
      prev_hs = hsync;
    end
  end

  initial begin
    bit seen;
    rst = 1;
    @(negedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    #2 check("idle_ren", fifo_ren, 0);
    check("idle_rgb", rgb, 0);

    // First word: pixels 0..7 each held PD clocks
    fq.push_back(25'h0FAC688);
    feed_en = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #2;
      if (fifo_ren) seen = 1;
    end
    check("first_pop_seen", seen, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #2;
      check("first_word_rgb", rgb, i / 2);
    end

    repeat (FR * PD * 3) @(negedge clk);
    check("no_underflow", underflow, 0);

    // Starve one load slot at line 2, pixel 16; refill right after
    starve_pix = 2 * HT + 16;
    starve_en = 1;
    repeat (FR * PD + 10) @(negedge clk);
    starve_en = 0;
    #2 check("underflow_set", underflow, 1);
    repeat (FR * PD) @(negedge clk);
    #2 check("underflow_sticky", underflow, 1);

    // Reset mid-frame at line 5, pixel 30
    seen = 0;
    for (int i = 0; i < FR * PD * 2 && !seen; i++) begin
      @(negedge clk);
      if (running && (run_cyc % PD == 0) && ((run_cyc / PD) % FR == 5 * HT + 30)) seen = 1;
    end
    check("midframe_reached", seen, 1);
    rst = 1;
    feed_en = 0;
    fq.delete();
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    #2 check("post_rst_uf", underflow, 0);
    check("post_rst_hs", hsync, 1);
    feed_en = 1;
    repeat (FR * PD + 50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
